// File: rtl/score_display.sv
// Three-digit multiplexed 7-segment driver for the score counter with a per-frame digit snapshot.
// Optional leading-zero blanking is enabled by defining SCORE_DISPLAY_LZB_EN.
module score_display #(
   parameter int unsigned REFRESH_DIV = 100000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] hundreds_digit,
   input  logic [3:0] tens_digit,
   input  logic [3:0] ones_digit,
   input  logic       blank,
   output logic [6:0] seg,
   output logic [3:0] an
);

   localparam int unsigned CNT_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int unsigned SNAP_W = 12;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

   typedef enum logic [1:0] {
      ONES     = 2'd0,
      TENS     = 2'd1,
      HUNDREDS = 2'd2
   } idx_t;

   logic [CNT_W-1:0]  cnt;
   idx_t              idx;
   logic [SNAP_W-1:0] snap;
   logic              tc_c;
   logic [3:0]        digit_c;
   logic [3:0]        anode_c;
   logic [6:0]        seg_c;

   assign tc_c = (cnt == CNT_MAX);

   // Slot timer: one digit slot lasts REFRESH_DIV cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (tc_c) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   // Scan index; the illegal encoding falls back to ONES at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx <= ONES;
      end else begin
         case (idx)
            ONES:     if (tc_c) idx <= TENS;
            TENS:     if (tc_c) idx <= HUNDREDS;
            HUNDREDS: if (tc_c) idx <= ONES;
            default:  idx <= ONES;
         endcase
      end
   end

   // Snapshot taken once per frame so a frame never mixes two scores.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         snap <= '0;
      end else if (tc_c && (idx == HUNDREDS)) begin
         snap <= {hundreds_digit, tens_digit, ones_digit};
      end
   end

   // Digit and anode selection from the snapshot.
   always_comb begin
      digit_c = 4'd0;
      anode_c = 4'b1111;
      case (idx)
         ONES: begin
            digit_c = snap[3:0];
            anode_c = 4'b1110;
         end
         TENS: begin
            digit_c = snap[7:4];
            anode_c = 4'b1101;
         end
         HUNDREDS: begin
            digit_c = snap[11:8];
            anode_c = 4'b1011;
         end
         default: begin
            digit_c = 4'd0;
            anode_c = 4'b1111;
         end
      endcase
`ifdef SCORE_DISPLAY_LZB_EN
      if ((idx == HUNDREDS) && (snap[11:8] == 4'd0)) begin
         anode_c = 4'b1111;
      end
      if ((idx == TENS) && (snap[11:8] == 4'd0) && (snap[7:4] == 4'd0)) begin
         anode_c = 4'b1111;
      end
`endif
   end

   // Active-low {g,f,e,d,c,b,a}; non-BCD codes show a dash.
   always_comb begin
      seg_c = 7'b0111111;
      case (digit_c)
         4'd0:    seg_c = 7'b1000000;
         4'd1:    seg_c = 7'b1111001;
         4'd2:    seg_c = 7'b0100100;
         4'd3:    seg_c = 7'b0110000;
         4'd4:    seg_c = 7'b0011001;
         4'd5:    seg_c = 7'b0010010;
         4'd6:    seg_c = 7'b0000010;
         4'd7:    seg_c = 7'b1111000;
         4'd8:    seg_c = 7'b0000000;
         4'd9:    seg_c = 7'b0010000;
         default: seg_c = 7'b0111111;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg <= 7'b1111111;
         an  <= 4'b1111;
      end else begin
         seg <= seg_c;
         an  <= blank ? 4'b1111 : anode_c;
      end
   end

endmodule

// File: tb/tb_score_display.sv
// Scoreboard bench for score_display: a cycle-indexed reference pushes expected seg/an per edge.
// Leading-zero expectations follow SCORE_DISPLAY_LZB_EN when it is defined for the build.
module tb_score_display;

   localparam int unsigned RD    = 4;
   localparam int unsigned FRAME = 3 * RD;

   logic       clk;
   logic       rst_n;
   logic [3:0] hundreds_digit;
   logic [3:0] tens_digit;
   logic [3:0] ones_digit;
   logic       blank;
   logic [6:0] seg;
   logic [3:0] an;

   logic          track;
   int unsigned   m_k;
   logic [11:0]   m_snap;
   logic [10:0]   exp_q[$];
   int            n_checks;
   int            n_errors;
   logic          found;

   score_display #(.REFRESH_DIV(RD)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .hundreds_digit (hundreds_digit),
      .tens_digit     (tens_digit),
      .ones_digit     (ones_digit),
      .blank          (blank),
      .seg            (seg),
      .an             (an)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [6:0] enc(input logic [3:0] d);
      logic [6:0] table_v [16];
      table_v = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                  7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
      return table_v[d];
   endfunction

   // Expected output after an edge, given the pre-edge cycle position p since reset.
   function automatic logic [10:0] predict(input int unsigned p, input logic [11:0] s,
                                           input logic blk);
      int unsigned slot;
      logic [3:0]  d;
      logic [3:0]  a;
      slot = (p / RD) % 3;
      d = (slot == 0) ? s[3:0] : (slot == 1) ? s[7:4] : s[11:8];
      a = (slot == 0) ? 4'b1110 : (slot == 1) ? 4'b1101 : 4'b1011;
`ifdef SCORE_DISPLAY_LZB_EN
      if (slot == 2 && s[11:8] == 4'd0) a = 4'b1111;
      if (slot == 1 && s[11:4] == 8'd0) a = 4'b1111;
`endif
      if (blk) a = 4'b1111;
      return {enc(d), a};
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_k    <= 0;
         m_snap <= 12'h000;
      end else if (track) begin
         exp_q.push_back(predict(m_k, m_snap, blank));
         m_k <= m_k + 1;
         if (((m_k + 1) % FRAME) == 0) m_snap <= {hundreds_digit, tens_digit, ones_digit};
      end
   end

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         check("seg", 32'(seg), 32'(exp_q[0][10:4]));
         check("an", 32'(an), 32'(exp_q[0][3:0]));
         void'(exp_q.pop_front());
      end
   end

   task automatic run(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic set_digits(input logic [3:0] h, input logic [3:0] t, input logic [3:0] o);
      hundreds_digit = h;
      tens_digit     = t;
      ones_digit     = o;
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      track    = 1'b0;
      rst_n    = 1'b0;
      blank    = 1'b0;
      found    = 1'b0;
      set_digits(4'd1, 4'd2, 4'd3);
      run(3);
      check("rst_seg", 32'(seg), 32'h7F);
      check("rst_an", 32'(an), 32'hF);

      // Release: zeros for one frame, then 3/2/1.
      rst_n = 1'b1;
      track = 1'b1;
      run(2 * FRAME);

      // 456 latched at the next frame edge; 789 arrives mid tens slot.
      set_digits(4'd4, 4'd5, 4'd6);
      run(FRAME + 5);
      set_digits(4'd7, 4'd8, 4'd9);
      run(FRAME + 7);

      // Invalid BCD in the tens position.
      set_digits(4'd4, 4'hC, 4'd2);
      run(2 * FRAME);

      // Blank across a slot boundary.
      blank = 1'b1;
      run(6);
      blank = 1'b0;
      run(FRAME);

      // Leading zeros.
      set_digits(4'd0, 4'd0, 4'd7);
      run(2 * FRAME);

      // Async reset in the middle of the tens slot.
      for (int i = 0; i < 2 * FRAME; i++) begin
         if ((m_k % FRAME) == RD + 1) begin
            found = 1'b1;
            break;
         end
         @(negedge clk);
      end
      check("tens_slot_found", 32'(found), 32'h1);
      #2;
      track = 1'b0;
      rst_n = 1'b0;
      #1;
      check("async_rst_seg", 32'(seg), 32'h7F);
      check("async_rst_an", 32'(an), 32'hF);
      exp_q.delete();
      @(negedge clk);
      set_digits(4'd9, 4'd8, 4'd7);
      rst_n = 1'b1;
      track = 1'b1;
      run(2 * FRAME);

      track = 1'b0;
      run(2);
      check("drain", 32'(exp_q.size()), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
